// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator display path.
// Segment vectors use bit0=a .. bit6=g, 1 = lit.
package calc_pkg;

  localparam int unsigned N_DIGITS = 8;

  typedef logic [6:0] seg_t;

  typedef enum logic [1:0] {
    ST_OK   = 2'b00,
    ST_BUSY = 2'b01,
    ST_ERR  = 2'b10,
    ST_RSV  = 2'b11
  } status_t;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } scan_state_t;

  localparam seg_t SEG_OFF = 7'b0;

  function automatic logic [N_DIGITS-1:0] digit_onehot(input logic [2:0] idx);
    return N_DIGITS'(1) << idx;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Phase timer: counts clocks elapsed in the current phase and flags the last one.
// A synchronous clear restarts the count when the scanner changes phase.
module tick_gen #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] load,
  output logic             first,
  output logic             tick
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == load);
  assign first = (cnt_q == '0);

  // Saturates at the terminal count so an idle phase cannot wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (!tick) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/disp_scan_mux.sv
// Time-multiplexes eight 7-segment digits onto one segment bus with dead time between
// digits, per-frame input snapshots, and whole-display blinking on calculator error.
module disp_scan_mux
  import calc_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 100000,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter int unsigned BLINK_LOG2   = 5,
  parameter int unsigned ACTIVE_LOW   = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [6:0] displays [N_DIGITS-1:0],
  input  logic [1:0] status,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int unsigned CNT_MAX = ((CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES) - 1;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic        INV     = (ACTIVE_LOW != 0);

  scan_state_t             state_q, state_d;
  logic [2:0]              idx_q, idx_d;
  logic [BLINK_LOG2:0]     frame_cnt_q;
  seg_t                    shadow_q [N_DIGITS];
  status_t                 shadow_st_q;

  logic                    tick, first, clear, snap, blink;
  logic [CNT_W-1:0]        load;
  logic [N_DIGITS-1:0]     an_d;
  seg_t                    seg_d;
  logic                    dp_d;

  assign load  = (state_q == SHOW) ? CNT_W'(CLK_DIV - 1) : CNT_W'(BLANK_CYCLES - 1);
  assign clear = (state_d != state_q);
  // Snapshot only on the opening clock of digit 0's blank phase.
  assign snap  = enable && (state_q == BLANK) && (idx_q == 3'd0) && first;
  assign blink = (shadow_st_q == ST_ERR) && frame_cnt_q[BLINK_LOG2];

  tick_gen #(
    .WIDTH(CNT_W)
  ) u_tick_gen (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .load (load),
    .first(first),
    .tick (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= BLANK;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          idx_d   = 3'd0;
        end
        BLANK: if (tick) state_d = SHOW;
        SHOW: begin
          if (tick) begin
            state_d = BLANK;
            idx_d   = idx_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    an_d  = '0;
    seg_d = SEG_OFF;
    dp_d  = 1'b0;
    if (enable && (state_q == SHOW)) begin
      an_d  = blink ? '0 : digit_onehot(idx_q);
      seg_d = shadow_q[idx_q];
      dp_d  = (idx_q == 3'd0) && (shadow_st_q == ST_BUSY);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_DIGITS; i++) shadow_q[i] <= SEG_OFF;
      shadow_st_q <= ST_OK;
      frame_cnt_q <= '0;
    end else if (snap) begin
      for (int i = 0; i < N_DIGITS; i++) shadow_q[i] <= displays[i];
      shadow_st_q <= status_t'(status);
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an          <= {8{INV}};
      seg         <= {7{INV}};
      dp          <= INV;
      frame_start <= 1'b0;
    end else begin
      an          <= an_d ^ {8{INV}};
      seg         <= seg_d ^ {7{INV}};
      dp          <= dp_d ^ INV;
      frame_start <= snap;
    end
  end

endmodule
